// File: rtl/register_dump_reader.sv
// Snapshots the architectural register file on a start request and streams the
// selected registers out as (index, data) words, lowest index first.
module register_dump_reader #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NREGS-1:0][DATA_W-1:0]         ioRegisters,
  input  logic                                 dumpStart,
  input  logic [NREGS-1:0]                     regMask,
  input  logic                                 dumpReady,
  output logic                                 dumpValid,
  output logic [$clog2(NREGS)-1:0]             dumpIndex,
  output logic [DATA_W-1:0]                    dumpData,
  output logic                                 dumpLast,
  output logic                                 busy,
  output logic                                 done
);

  localparam int IDX_W = $clog2(NREGS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [NREGS-1:0] MASK_ONE = NREGS'(1);

  logic [1:0]              state_reg;
  logic [1:0]              state_next;
  logic [NREGS-1:0]        pending_reg;
  logic [NREGS-1:0]        pending_next;
  logic [NREGS*DATA_W-1:0] snap_flat;
  logic                    take_snap;

  logic [NREGS-1:0]        lowest_bit;
  logic [NREGS-1:0]        pending_rest;
  logic [IDX_W-1:0]        cur_idx;
  logic                    in_send;

  assign take_snap = (state_reg == ST_IDLE) && dumpStart;

  // One word-wide register per architectural register, all loaded in the
  // same cycle so the dump sees a coherent image of the file.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_snap
      logic [DATA_W-1:0] word_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          word_reg <= '0;
        end else if (take_snap) begin
          word_reg <= ioRegisters[gi];
        end
      end

      assign snap_flat[gi*DATA_W +: DATA_W] = word_reg;
    end
  endgenerate

  // Two's-complement trick isolates the lowest pending bit.
  assign lowest_bit   = pending_reg & (~pending_reg + MASK_ONE);
  assign pending_rest = pending_reg & ~lowest_bit;

  always_comb begin
    cur_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        cur_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    case (state_reg)
      ST_IDLE: begin
        if (dumpStart) begin
          pending_next = regMask;
          state_next   = (regMask != '0) ? ST_SEND : ST_DONE;
        end
      end
      ST_SEND: begin
        if (dumpReady) begin
          pending_next = pending_rest;
          if (pending_rest == '0) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next   = ST_IDLE;
        pending_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

  // Outputs decode registered state only, so dumpReady never reaches them.
  assign in_send   = (state_reg == ST_SEND);
  assign dumpValid = in_send;
  assign dumpIndex = in_send ? cur_idx : '0;
  assign dumpData  = in_send ? snap_flat[cur_idx*DATA_W +: DATA_W] : '0;
  assign dumpLast  = in_send && (pending_rest == '0);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_register_dump_reader.sv
// Directed bench for register_dump_reader: table of dump scenarios plus a
// hand-written asynchronous reset sequence.
module tb_register_dump_reader;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [31:0][31:0]     reg_file;
  logic                  dumpStart;
  logic [31:0]           regMask;
  logic                  dumpReady;
  logic                  dumpValid;
  logic [4:0]            dumpIndex;
  logic [31:0]           dumpData;
  logic                  dumpLast;
  logic                  busy;
  logic                  done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_dump_reader #(.NREGS(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .ioRegisters(reg_file),
    .dumpStart  (dumpStart),
    .regMask    (regMask),
    .dumpReady  (dumpReady),
    .dumpValid  (dumpValid),
    .dumpIndex  (dumpIndex),
    .dumpData   (dumpData),
    .dumpLast   (dumpLast),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [31:0] mask;
    int          stall;
    bit          toggle;
    int          pre_idx;
    logic [31:0] pre_val;
    int          wr_cyc;
    int          wr_idx;
    logic [31:0] wr_val;
    int          start_cyc;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) reg_file[i] = 32'h1000_0000 + i;
  endtask

  // Runs one dump from the negedge before the start edge through return to IDLE.
  task automatic do_dump(input vec_t v, input string tag);
    int          exp_idx[$];
    logic [31:0] snap [32];
    int          k;
    int          cyc;
    for (int i = 0; i < 32; i++) if (v.mask[i]) exp_idx.push_back(i);
    @(negedge clk);
    for (int i = 0; i < 32; i++) snap[i] = reg_file[i];
    dumpStart = 1'b1;
    regMask   = v.mask;
    dumpReady = 1'b0;
    @(negedge clk);
    dumpStart = 1'b0;
    regMask   = 32'hDEAD_BEEF;
    check({tag, " busy_after_start"}, {31'b0, busy}, 32'd1);
    k   = 0;
    cyc = 0;
    while (k < exp_idx.size() && cyc < 400) begin
      if (cyc == v.wr_cyc) reg_file[v.wr_idx] = v.wr_val;
      dumpStart = (cyc == v.start_cyc);
      if (cyc == v.start_cyc) regMask = 32'hFFFF_FFFF;
      if (cyc < v.stall)   dumpReady = 1'b0;
      else if (v.toggle)   dumpReady = ((cyc - v.stall) % 2 == 0);
      else                 dumpReady = 1'b1;
      check({tag, " valid"}, {31'b0, dumpValid}, 32'd1);
      check({tag, " index"}, {27'b0, dumpIndex}, exp_idx[k]);
      check({tag, " data"}, dumpData, snap[exp_idx[k]]);
      check({tag, " last"}, {31'b0, dumpLast}, {31'b0, (k == exp_idx.size() - 1)});
      $display("%s word %0d: idx=%0d data=0x%08h last=%0b ready=%0b",
               tag, k, dumpIndex, dumpData, dumpLast, dumpReady);
      if (dumpReady) k++;
      @(negedge clk);
      cyc++;
    end
    dumpStart = 1'b0;
    check({tag, " words_sent"}, k, exp_idx.size());
    check({tag, " done_pulse"}, {31'b0, done}, 32'd1);
    check({tag, " valid_in_done"}, {31'b0, dumpValid}, 32'd0);
    check({tag, " busy_in_done"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    check({tag, " done_cleared"}, {31'b0, done}, 32'd0);
    check({tag, " idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, " idle_valid"}, {31'b0, dumpValid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   cyc;

    vecs[0] = '{mask:32'hFFFF_FFFF, stall:0, toggle:0, pre_idx:-1, pre_val:0,
                wr_cyc:-1, wr_idx:0, wr_val:0, start_cyc:-1};
    vecs[1] = '{mask:32'h8000_0005, stall:0, toggle:0, pre_idx:-1, pre_val:0,
                wr_cyc:-1, wr_idx:0, wr_val:0, start_cyc:-1};
    vecs[2] = '{mask:32'h0000_0006, stall:5, toggle:1, pre_idx:-1, pre_val:0,
                wr_cyc:-1, wr_idx:0, wr_val:0, start_cyc:-1};
    vecs[3] = '{mask:32'h0000_000A, stall:5, toggle:0, pre_idx:3, pre_val:32'hAAAA_AAAA,
                wr_cyc:2, wr_idx:3, wr_val:32'h5555_5555, start_cyc:-1};
    vecs[4] = '{mask:32'h0000_0000, stall:0, toggle:0, pre_idx:-1, pre_val:0,
                wr_cyc:-1, wr_idx:0, wr_val:0, start_cyc:-1};
    vecs[5] = '{mask:32'h0000_0F00, stall:0, toggle:0, pre_idx:-1, pre_val:0,
                wr_cyc:-1, wr_idx:0, wr_val:0, start_cyc:1};
    vecs[6] = '{mask:32'h0000_0001, stall:0, toggle:0, pre_idx:0, pre_val:32'hCAFE_0000,
                wr_cyc:0, wr_idx:0, wr_val:32'h0BAD_0BAD, start_cyc:-1};

    reset     = 1'b0;
    dumpStart = 1'b0;
    dumpReady = 1'b0;
    regMask   = '0;
    preload();
    #1;
    check("reset valid", {31'b0, dumpValid}, 32'd0);
    check("reset index", {27'b0, dumpIndex}, 32'd0);
    check("reset data", dumpData, 32'd0);
    check("reset last", {31'b0, dumpLast}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 7; n++) begin
      v = vecs[n];
      preload();
      if (v.pre_idx >= 0) reg_file[v.pre_idx] = v.pre_val;
      do_dump(v, $sformatf("v%0d", n));
    end

    // Asynchronous reset while word 4 of a full dump is on the output.
    preload();
    @(negedge clk);
    dumpStart = 1'b1;
    regMask   = 32'hFFFF_FFFF;
    dumpReady = 1'b1;
    @(negedge clk);
    dumpStart = 1'b0;
    cyc = 0;
    while (dumpIndex != 5'd4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rst word4 reached", {27'b0, dumpIndex}, 32'd4);
    #2;
    reset = 1'b0;
    #1;
    $display("async reset asserted: valid=%0b idx=%0d data=0x%08h busy=%0b",
             dumpValid, dumpIndex, dumpData, busy);
    check("rst valid", {31'b0, dumpValid}, 32'd0);
    check("rst index", {27'b0, dumpIndex}, 32'd0);
    check("rst data", dumpData, 32'd0);
    check("rst last", {31'b0, dumpLast}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("rst held done", {31'b0, done}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post rst done", {31'b0, done}, 32'd0);
    check("post rst busy", {31'b0, busy}, 32'd0);
    check("post rst valid", {31'b0, dumpValid}, 32'd0);
    v = '{mask:32'h0000_0001, stall:0, toggle:0, pre_idx:-1, pre_val:0,
          wr_cyc:-1, wr_idx:0, wr_val:0, start_cyc:-1};
    do_dump(v, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
